smplfifo_ctl: RTL and testbench
===============================

// Module: smplfifo_ctl
// PURPOSE
//  Parametrised sample FIFO for the sensor/audio capture paths (PMod MIC and
//  similar). Sits between a sample producer and a bus-side consumer.
//  - Holds up to the full 2^LGFLEN samples.
//  - Read side is first-word-fall-through.
//  - Run-time overflow policy: drop newest or overwrite oldest.
//  - Programmable fill-threshold interrupt.
//  - Sticky overflow and underflow flags, plus a 32-bit status word.
// PARAMETERS
//  BW      12  sample width in bits
//  LGFLEN   9  log2 of FIFO depth; legal range 2..15
// PORTS
//  i_clk      in   1         clock
//  i_rst_n    in   1         reset, asynchronous, active-low
//  i_clr      in   1         synchronous flush: pointers, fill and flags to 0
//  i_mode     in   1         0 = drop newest on overflow, 1 = overwrite oldest
//  i_thresh   in   LGFLEN+1  interrupt threshold in samples; 0 disables o_int
//  i_wr       in   1         write strobe
//  i_data     in   BW        write data
//  i_rd       in   1         read strobe; consumes o_data
//  o_data     out  BW        oldest sample; valid while o_empty_n=1
//  o_empty_n  out  1         FIFO holds at least 1 sample
//  o_full     out  1         fill == 2^LGFLEN
//  o_fill     out  LGFLEN+1  sample count, 0..2^LGFLEN
//  o_int      out  1         registered: (i_thresh!=0) && (o_fill>=i_thresh)
//  o_err      out  1         sticky overflow OR sticky underflow
//  o_peak     out  LGFLEN+1  high-water mark (see CONFIGURATION)
//  o_status   out  32        [31:16] o_fill zero-extended; [15:5] 0; [4] o_int;
//                            [3] underflow; [2] overflow; [1] o_full; [0] o_empty_n
// BEHAVIOUR
//  - Reset (async, i_rst_n=0):
//    - pointers 0, o_fill=0, o_empty_n=0, o_full=0, o_int=0, o_err=0, o_peak=0.
//    - o_data=0 until the first write.
//    - Memory contents are not reset.
//  - Pointers are LGFLEN+1 bits wide; full/empty are resolved by the MSB.
//    Wrap-around is modulo 2^(LGFLEN+1).
//  - All flags and o_fill are registered and reflect the state after this
//    cycle's accepted operations.
//    - Write into an empty FIFO: o_empty_n=1 and o_data valid on the next cycle.
//  - After a read, o_data shows the next sample on the next cycle (FWFT).
//    - Back-to-back reads each cycle are supported at full rate.
//  - Read while empty: ignored, pointers unchanged, underflow flag set.
//  - Write while not full: stored; fill+1.
//  - Read and write in the same cycle, not empty: both accepted, fill unchanged.
//    - This also holds when full: no overflow is flagged.
//    - When fill==1, o_data becomes the new write data on the next cycle.
//  - Read and write in the same cycle while empty: the write is accepted and
//    the read is ignored (underflow flag set); fill=1.
//  - Write while full, no read:
//    - i_mode=0: sample discarded, memory untouched, overflow flag set.
//    - i_mode=1: oldest sample discarded (read pointer advances), new sample
//      stored, fill stays 2^LGFLEN, overflow flag set.
//  - i_clr has priority over i_wr and i_rd in the same cycle.
//    - It empties the FIFO and clears both sticky flags and o_peak.
//    - Result on the next cycle matches the reset state.
//  - A change to i_thresh or i_mode takes effect on the next cycle; no pipeline
//    drain is needed.
//  - Reset asserted mid-transfer aborts immediately; no partial state is retained.
// CONFIGURATION
//  - SMPLFIFO_PEAK_EN defined:
//    - o_peak tracks max(o_fill) since the last reset or i_clr.
//    - It updates in the same cycle as o_fill.
//  - SMPLFIFO_PEAK_EN undefined:
//    - o_peak is tied to 0 and no peak register is synthesised.
// STRUCTURE
//  - Package smplfifo_pkg holds:
//    - status bit indices: ST_EMPTY_N=0, ST_FULL=1, ST_OVFL=2, ST_UNFL=3,
//      ST_INT=4, ST_FILL_LSB=16;
//    - mode encodings: MODE_DROP=1'b0, MODE_OVW=1'b1.
//  - One sub-module, smplfifo_ram: simple dual-port RAM, BW x 2^LGFLEN, with a
//    synchronous read port.
//    - The top level provides FWFT with a bypass register for the write-to-empty
//      and fill==1 cases.
// TESTING (bench: BW=12, LGFLEN=4, depth 16)
//  1. Reset, then write 0x001..0x010 -> o_full=1, o_fill=16, o_data=0x001;
//     16 reads return 0x001..0x010 in order; o_empty_n=0 afterwards.
//  2. Full, i_mode=0, write 0xABC -> overflow=1, o_fill=16; reads return
//     0x001..0x010 and 0xABC is never seen.
//  3. Full, i_mode=1, write 0xABC -> overflow=1; reads return 0x002..0x010
//     then 0xABC.
//  4. Empty, then write 0x123 with i_rd=1 in the same cycle -> fill=1, o_data=0x123,
//     underflow=1. Next cycle rd+wr 0x456 -> fill stays 1, o_data=0x456.
//  5. i_thresh=8: 7 writes -> o_int=0; 8th write -> o_int=1 the next cycle;
//     one read -> o_int=0.
//  6. Fill 10 then read to 3; i_clr -> fill=0, o_err=0, o_peak=0. With
//     SMPLFIFO_PEAK_EN, o_peak=10 before the clear. Async reset mid-write
//     -> all outputs at reset values.

Source files
------------

// File: rtl/smplfifo_pkg.sv
// Shared definitions for the sample FIFO: status word bit positions,
// overflow-policy encodings and the status word packer.
package smplfifo_pkg;

   // Bit positions inside the 32-bit status word
   localparam int ST_EMPTY_N  = 0;
   localparam int ST_FULL     = 1;
   localparam int ST_OVFL     = 2;
   localparam int ST_UNFL     = 3;
   localparam int ST_INT      = 4;
   localparam int ST_FILL_LSB = 16;

   // Overflow policy selected by i_mode
   localparam logic MODE_DROP = 1'b0;
   localparam logic MODE_OVW  = 1'b1;

   // Assemble the status word; fill arrives already zero-extended to 16 bits
   function automatic logic [31:0] pack_status(input logic [15:0] fill,
                                               input logic       intr,
                                               input logic       unfl,
                                               input logic       ovfl,
                                               input logic       full,
                                               input logic       empty_n);
      logic [31:0] st;
      st                              = '0;
      st[ST_FILL_LSB +: 16]           = fill;
      st[ST_INT]                      = intr;
      st[ST_UNFL]                     = unfl;
      st[ST_OVFL]                     = ovfl;
      st[ST_FULL]                     = full;
      st[ST_EMPTY_N]                  = empty_n;
      return st;
   endfunction

endpackage

// File: rtl/smplfifo_ram.sv
// Simple dual-port sample storage, BW x 2^LGFLEN, one write port and one
// registered read port. Contents are never reset.
module smplfifo_ram
   import smplfifo_pkg::*;
#(
   parameter int BW     = 12,
   parameter int LGFLEN = 9
)(
   input  logic              i_clk,
   input  logic              i_we,
   input  logic [LGFLEN-1:0] i_waddr,
   input  logic [BW-1:0]     i_wdata,
   input  logic [LGFLEN-1:0] i_raddr,
   output logic [BW-1:0]     o_rdata
);

   logic [BW-1:0] mem [2**LGFLEN];

   // Write port
   always_ff @(posedge i_clk) begin
      if (i_we) begin
         mem[i_waddr] <= i_wdata;
      end
   end

   // Registered read port; a same-cycle write to i_raddr returns old data
   always_ff @(posedge i_clk) begin
      o_rdata <= mem[i_raddr];
   end

endmodule

// File: rtl/smplfifo_ctl.sv
// Sample FIFO controller: first-word-fall-through read side, run-time
// selectable overflow policy (drop newest / overwrite oldest), fill-threshold
// interrupt, sticky overflow/underflow flags and a 32-bit status word.
// Optional build macro SMPLFIFO_PEAK_EN enables the high-water mark on o_peak;
// without it o_peak is tied to zero and no peak register exists.
module smplfifo_ctl
   import smplfifo_pkg::*;
#(
   parameter int BW     = 12,
   parameter int LGFLEN = 9
)(
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_clr,
   input  logic              i_mode,
   input  logic [LGFLEN:0]   i_thresh,
   input  logic              i_wr,
   input  logic [BW-1:0]     i_data,
   input  logic              i_rd,
   output logic [BW-1:0]     o_data,
   output logic              o_empty_n,
   output logic              o_full,
   output logic [LGFLEN:0]   o_fill,
   output logic              o_int,
   output logic              o_err,
   output logic [LGFLEN:0]   o_peak,
   output logic [31:0]       o_status
);

   localparam int PW = LGFLEN + 1;

   // Pointers carry one extra wrap bit so full and empty are distinguishable
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr_nxt;
   logic [PW-1:0] rd_ptr_nxt;
   logic [PW-1:0] fill_nxt;

   logic          cur_empty;
   logic          cur_full;
   logic          rd_ok;
   logic          wr_ok;
   logic          ovw;
   logic          ovfl_evt;
   logic          unfl_evt;
   logic          ram_we;
   logic          byp_hit;
   logic          rd_adv;

   logic          ovfl_flg;
   logic          unfl_flg;
   logic          byp_sel;
   logic [BW-1:0] byp_data;
   logic [BW-1:0] ram_q;

   // Accept/reject decisions and next pointer values for this cycle
   always_comb begin
      cur_empty  = (wr_ptr == rd_ptr);
      cur_full   = (wr_ptr[LGFLEN] != rd_ptr[LGFLEN]) &&
                   (wr_ptr[LGFLEN-1:0] == rd_ptr[LGFLEN-1:0]);
      rd_ok      = i_rd && !cur_empty;
      unfl_evt   = i_rd && cur_empty;
      // A simultaneous read frees a slot, so a full FIFO only overflows
      // when nothing is being consumed
      ovfl_evt   = i_wr && cur_full && !rd_ok;
      ovw        = ovfl_evt && (i_mode == MODE_OVW);
      wr_ok      = i_wr && (!cur_full || rd_ok || ovw);
      ram_we     = wr_ok && !i_clr;
      wr_ptr_nxt = wr_ptr;
      rd_ptr_nxt = rd_ptr;
      if (i_clr) begin
         wr_ptr_nxt = '0;
         rd_ptr_nxt = '0;
      end else begin
         if (wr_ok) begin
            wr_ptr_nxt = wr_ptr + PW'(1);
         end
         // Overwrite mode retires the oldest sample to make room
         if (rd_ok || ovw) begin
            rd_ptr_nxt = rd_ptr + PW'(1);
         end
      end
      rd_adv   = (rd_ptr_nxt != rd_ptr);
      fill_nxt = wr_ptr_nxt - rd_ptr_nxt;
      // The RAM read of the next head location misses a write landing on the
      // same address this cycle (write into empty, or rd+wr at fill==1)
      byp_hit  = ram_we && (wr_ptr[LGFLEN-1:0] == rd_ptr_nxt[LGFLEN-1:0]);
   end

   // Pointer, fill, flag and interrupt registers
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         o_fill    <= '0;
         o_empty_n <= 1'b0;
         o_full    <= 1'b0;
         o_int     <= 1'b0;
         ovfl_flg  <= 1'b0;
         unfl_flg  <= 1'b0;
      end else begin
         wr_ptr    <= wr_ptr_nxt;
         rd_ptr    <= rd_ptr_nxt;
         o_fill    <= fill_nxt;
         o_empty_n <= (fill_nxt != '0);
         o_full    <= fill_nxt[LGFLEN];
         o_int     <= (i_thresh != '0) && (fill_nxt >= i_thresh);
         if (i_clr) begin
            ovfl_flg <= 1'b0;
            unfl_flg <= 1'b0;
         end else begin
            ovfl_flg <= ovfl_flg | ovfl_evt;
            unfl_flg <= unfl_flg | unfl_evt;
         end
      end
   end

   // Bypass register: holds the head sample whenever the RAM cannot yet
   // present it; reset/clear make the head read back as zero
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         byp_sel  <= 1'b1;
         byp_data <= '0;
      end else if (i_clr) begin
         byp_sel  <= 1'b1;
         byp_data <= '0;
      end else if (byp_hit) begin
         byp_sel  <= 1'b1;
         byp_data <= i_data;
      end else if (rd_adv) begin
         byp_sel  <= 1'b0;
      end
   end

   smplfifo_ram #(
      .BW     (BW),
      .LGFLEN (LGFLEN)
   ) u_ram (
      .i_clk   (i_clk),
      .i_we    (ram_we),
      .i_waddr (wr_ptr[LGFLEN-1:0]),
      .i_wdata (i_data),
      .i_raddr (rd_ptr_nxt[LGFLEN-1:0]),
      .o_rdata (ram_q)
   );

   assign o_data   = byp_sel ? byp_data : ram_q;
   assign o_err    = ovfl_flg | unfl_flg;
   assign o_status = pack_status(16'(o_fill), o_int, unfl_flg, ovfl_flg,
                                 o_full, o_empty_n);

`ifdef SMPLFIFO_PEAK_EN
   logic [PW-1:0] peak_q;

   // High-water mark, tracking the same next-fill value that loads o_fill
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         peak_q <= '0;
      end else if (i_clr) begin
         peak_q <= '0;
      end else if (fill_nxt > peak_q) begin
         peak_q <= fill_nxt;
      end
   end

   assign o_peak = peak_q;
`else
   assign o_peak = '0;
`endif

endmodule

// File: tb/tb_smplfifo_ctl.sv
// Directed bench for smplfifo_ctl (BW=12, LGFLEN=4): a queue scoreboard
// receives every accepted sample and is popped as the DUT consumes them.
module tb_smplfifo_ctl;

   localparam int BW     = 12;
   localparam int LGFLEN = 4;
   localparam int DEPTH  = 16;

   logic              clk = 1'b0;
   logic              i_rst_n;
   logic              i_clr;
   logic              i_mode;
   logic [LGFLEN:0]   i_thresh;
   logic              i_wr;
   logic [BW-1:0]     i_data;
   logic              i_rd;
   logic [BW-1:0]     o_data;
   logic              o_empty_n;
   logic              o_full;
   logic [LGFLEN:0]   o_fill;
   logic              o_int;
   logic              o_err;
   logic [LGFLEN:0]   o_peak;
   logic [31:0]       o_status;

   int checks = 0;
   int errors = 0;

   logic [BW-1:0] sb[$];
   bit            m_ovfl;
   bit            m_unfl;
   bit            m_int;
   int            m_peak;

   smplfifo_ctl #(
      .BW     (BW),
      .LGFLEN (LGFLEN)
   ) dut (
      .i_clk     (clk),
      .i_rst_n   (i_rst_n),
      .i_clr     (i_clr),
      .i_mode    (i_mode),
      .i_thresh  (i_thresh),
      .i_wr      (i_wr),
      .i_data    (i_data),
      .i_rd      (i_rd),
      .o_data    (o_data),
      .o_empty_n (o_empty_n),
      .o_full    (o_full),
      .o_fill    (o_fill),
      .o_int     (o_int),
      .o_err     (o_err),
      .o_peak    (o_peak),
      .o_status  (o_status)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      sb.delete();
      m_ovfl = 1'b0;
      m_unfl = 1'b0;
      m_int  = 1'b0;
      m_peak = 0;
   endtask

   // Compare every registered output with the model
   task automatic check_state(input string tag);
      int          sz;
      logic [31:0] st;
      sz = sb.size();
      st = {16'(sz), 11'd0, m_int, m_unfl, m_ovfl, (sz == DEPTH), (sz > 0)};
      chk({tag, ".fill"},    32'(o_fill),    32'(sz));
      chk({tag, ".full"},    32'(o_full),    32'(sz == DEPTH));
      chk({tag, ".empty_n"}, 32'(o_empty_n), 32'(sz > 0));
      chk({tag, ".int"},     32'(o_int),     32'(m_int));
      chk({tag, ".err"},     32'(o_err),     32'(m_ovfl | m_unfl));
      chk({tag, ".status"},  o_status,       st);
`ifdef SMPLFIFO_PEAK_EN
      chk({tag, ".peak"},    32'(o_peak),    32'(m_peak));
`else
      chk({tag, ".peak"},    32'(o_peak),    32'd0);
`endif
      if (sz > 0) begin
         chk({tag, ".head"}, 32'(o_data), 32'(sb[0]));
      end
   endtask

   // One clock of traffic; the consumed sample is popped and compared
   task automatic cycle(input string tag, input logic wr, input logic [BW-1:0] d,
                        input logic rd);
      int pre;
      bit rd_ok;
      i_wr   = wr;
      i_data = d;
      i_rd   = rd;
      pre    = sb.size();
      rd_ok  = rd && (pre > 0);
      if (rd_ok) begin
         chk({tag, ".rd_data"}, 32'(o_data), 32'(sb[0]));
         void'(sb.pop_front());
      end
      if (rd && pre == 0) m_unfl = 1'b1;
      if (wr) begin
         if (pre < DEPTH || rd_ok) begin
            sb.push_back(d);
         end else begin
            m_ovfl = 1'b1;
            if (i_mode) begin
               void'(sb.pop_front());
               sb.push_back(d);
            end
         end
      end
      m_int = (i_thresh != 0) && (sb.size() >= int'(i_thresh));
      if (sb.size() > m_peak) m_peak = sb.size();
      @(posedge clk);
      #1;
      i_wr = 1'b0;
      i_rd = 1'b0;
      check_state(tag);
   endtask

   task automatic do_clr(input string tag);
      i_clr = 1'b1;
      i_wr  = 1'b1;
      i_rd  = 1'b1;
      i_data = 12'hFFF;
      model_reset();
      @(posedge clk);
      #1;
      i_clr = 1'b0;
      i_wr  = 1'b0;
      i_rd  = 1'b0;
      check_state(tag);
      chk({tag, ".data0"}, 32'(o_data), 32'd0);
   endtask

   initial begin
      i_rst_n  = 1'b0;
      i_clr    = 1'b0;
      i_mode   = 1'b0;
      i_thresh = '0;
      i_wr     = 1'b0;
      i_data   = '0;
      i_rd     = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check_state("rst");
      chk("rst.data0", 32'(o_data), 32'd0);
      i_rst_n = 1'b1;
      @(posedge clk);
      #1;
      check_state("rst_rel");
      chk("rst_rel.data0", 32'(o_data), 32'd0);

      // Fill to full, then drain in order
      for (int i = 1; i <= DEPTH; i++) cycle("t1_wr", 1'b1, 12'(i), 1'b0);
      chk("t1.full", 32'(o_full), 32'd1);
      chk("t1.head", 32'(o_data), 32'h001);
      for (int i = 0; i < DEPTH; i++) cycle("t1_rd", 1'b0, '0, 1'b1);
      chk("t1.empty_n", 32'(o_empty_n), 32'd0);

      // Drop-newest overflow
      for (int i = 1; i <= DEPTH; i++) cycle("t2_wr", 1'b1, 12'(i), 1'b0);
      cycle("t2_ovf", 1'b1, 12'hABC, 1'b0);
      chk("t2.ovfl_bit", 32'(o_status[2]), 32'd1);
      for (int i = 0; i < DEPTH; i++) cycle("t2_rd", 1'b0, '0, 1'b1);

      // Overwrite-oldest overflow
      for (int i = 1; i <= DEPTH; i++) cycle("t3_wr", 1'b1, 12'(i), 1'b0);
      i_mode = 1'b1;
      cycle("t3_mode", 1'b0, '0, 1'b0);
      cycle("t3_ovw", 1'b1, 12'hABC, 1'b0);
      chk("t3.head", 32'(o_data), 32'h002);
      i_mode = 1'b0;
      for (int i = 0; i < DEPTH; i++) cycle("t3_rd", 1'b0, '0, 1'b1);

      // Read+write while empty, then at fill==1
      do_clr("t4_clr");
      cycle("t4_rw_empty", 1'b1, 12'h123, 1'b1);
      chk("t4.data123", 32'(o_data), 32'h123);
      chk("t4.unfl_bit", 32'(o_status[3]), 32'd1);
      cycle("t4_rw_one", 1'b1, 12'h456, 1'b1);
      chk("t4.data456", 32'(o_data), 32'h456);
      cycle("t4_rd", 1'b0, '0, 1'b1);

      // Threshold interrupt
      do_clr("t5_clr");
      i_thresh = 5'd8;
      cycle("t5_thr", 1'b0, '0, 1'b0);
      for (int i = 0; i < 7; i++) cycle("t5_wr", 1'b1, 12'(12'h200 + i), 1'b0);
      chk("t5.int7", 32'(o_int), 32'd0);
      cycle("t5_wr8", 1'b1, 12'h2FF, 1'b0);
      chk("t5.int8", 32'(o_int), 32'd1);
      cycle("t5_rd", 1'b0, '0, 1'b1);
      chk("t5.int_rd", 32'(o_int), 32'd0);
      i_thresh = '0;
      cycle("t5_off", 1'b0, '0, 1'b0);

      // Peak tracking and clear
      do_clr("t6_clr0");
      for (int i = 0; i < 10; i++) cycle("t6_wr", 1'b1, 12'(12'h300 + i), 1'b0);
      for (int i = 0; i < 7; i++) cycle("t6_rd", 1'b0, '0, 1'b1);
      chk("t6.fill3", 32'(o_fill), 32'd3);
      do_clr("t6_clr");

      // Mixed streaming with simultaneous read/write
      for (int i = 0; i < 12; i++)
         cycle("mix", 1'(i % 3 != 2), 12'(12'h400 + i), 1'(i % 2));

      // Asynchronous reset in the middle of a write
      i_wr   = 1'b1;
      i_data = 12'h5A5;
      @(posedge clk);
      #2;
      i_rst_n = 1'b0;
      #1;
      model_reset();
      check_state("arst");
      chk("arst.data0", 32'(o_data), 32'd0);
      i_wr = 1'b0;
      @(posedge clk);
      #1;
      i_rst_n = 1'b1;
      cycle("post_wr", 1'b1, 12'h777, 1'b0);
      cycle("post_rd", 1'b0, '0, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
